// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared definitions for the 5-stage MIPS pipeline control logic.
//            Holds the pipeline controller state encoding and register-field
//            widths used by the hazard comparators.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Width of a register specifier field (rs/rt/rd)
  localparam int REG_AW = 5;

  // Pipeline controller state encoding
  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Purpose  : Load-use hazard comparator. Flags when the load in EX writes a
//            register that the instruction in ID reads. Register 0 never
//            creates a dependency.
// Ports    : i_if_id_rs      - rs of instruction in ID
//            i_if_id_rt      - rt of instruction in ID
//            i_id_ex_rt      - load destination of instruction in EX
//            i_id_ex_memread - instruction in EX is a load
//            o_hazard        - load-use hazard present this cycle
// Revision : 1.0 - initial release
// ============================================================================
module hazard_detect
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] i_if_id_rs,
  input  logic [REG_AW-1:0] i_if_id_rt,
  input  logic [REG_AW-1:0] i_id_ex_rt,
  input  logic              i_id_ex_memread,
  output logic              o_hazard
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_id_ex_rt == i_if_id_rs);
  assign w_rt_match = (i_id_ex_rt == i_if_id_rt);

  assign o_hazard = i_id_ex_memread && (i_id_ex_rt != '0) && (w_rs_match || w_rt_match);

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Central stall/flush sequencer for the 5-stage MIPS pipeline.
//            Combines load-use hazards, branch flushes and a handshaked
//            variable-latency data-memory access in MEM into per-stage
//            write-enable / flush / bubble controls. Counts stalled cycles
//            and raises a sticky timeout if memory never acknowledges.
// Ports    : clk_i, rst_i (async, active low)
//            IF_ID_RS_i/IF_ID_RT_i/ID_EX_RT_i/ID_EX_MemRead_i - hazard inputs
//            Branch_i - branch/jump resolved in ID
//            EX_MEM_MemRead_i/EX_MEM_MemWrite_i/dmem_ack_i - memory handshake
//            dmem_req_o, PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o,
//            ID_EX_Write_o, ID_EX_Bubble_o, EX_MEM_Write_o, MEM_WB_Bubble_o
//            stall_cnt_o - saturating stalled-cycle count
//            timeout_o   - sticky memory timeout
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = 64,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] IF_ID_RS_i,
  input  logic [REG_AW-1:0] IF_ID_RT_i,
  input  logic [REG_AW-1:0] ID_EX_RT_i,
  input  logic              ID_EX_MemRead_i,
  input  logic              Branch_i,
  input  logic              EX_MEM_MemRead_i,
  input  logic              EX_MEM_MemWrite_i,
  input  logic              dmem_ack_i,
  output logic              dmem_req_o,
  output logic              PCWrite_o,
  output logic              IF_ID_Write_o,
  output logic              IF_ID_Flush_o,
  output logic              ID_EX_Write_o,
  output logic              ID_EX_Bubble_o,
  output logic              EX_MEM_Write_o,
  output logic              MEM_WB_Bubble_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic              timeout_o
);

  localparam int WCW = $clog2(WAIT_MAX + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WCW-1:0]   r_wcnt;
  logic [WCW-1:0]   w_wcnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_mem_op;
  logic w_mem_stall;
  logic w_req;
  logic w_hazard;

  assign w_mem_op = EX_MEM_MemRead_i || EX_MEM_MemWrite_i;

  hazard_detect u_hazard_detect (
    .i_if_id_rs      (IF_ID_RS_i),
    .i_if_id_rt      (IF_ID_RT_i),
    .i_id_ex_rt      (ID_EX_RT_i),
    .i_id_ex_memread (ID_EX_MemRead_i),
    .o_hazard        (w_hazard)
  );

  // Next-state and memory-stall decode
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_mem_stall = 1'b0;
    w_req       = 1'b0;
    case (r_state)
      S_RUN: begin
        w_req = w_mem_op;
        // An ack in the same cycle as the request is a zero-wait access
        if (w_mem_op && !dmem_ack_i) begin
          w_mem_stall = 1'b1;
          w_state_nxt = S_WAIT;
          w_wcnt_nxt  = WCW'(1);
        end
      end
      S_WAIT: begin
        w_req = 1'b1;
        if (dmem_ack_i) begin
          // Released in the ack cycle so MEM_WB captures the result now
          w_state_nxt = S_RUN;
          w_wcnt_nxt  = '0;
        end else begin
          w_mem_stall = 1'b1;
          if (r_wcnt == WCW'(WAIT_MAX)) begin
            w_state_nxt = S_ERR;
          end else begin
            w_wcnt_nxt = r_wcnt + 1'b1;
          end
        end
      end
      S_ERR: begin
        w_mem_stall = 1'b1;
      end
      default: begin
        w_state_nxt = S_RUN;
        w_wcnt_nxt  = '0;
      end
    endcase
  end

  // Priority mux: mem stall (incl. ERR) > load-use > branch.
  // Held at defaults while reset is asserted, regardless of inputs.
  always_comb begin
    dmem_req_o      = 1'b0;
    PCWrite_o       = 1'b1;
    IF_ID_Write_o   = 1'b1;
    IF_ID_Flush_o   = 1'b0;
    ID_EX_Write_o   = 1'b1;
    ID_EX_Bubble_o  = 1'b0;
    EX_MEM_Write_o  = 1'b1;
    MEM_WB_Bubble_o = 1'b0;
    if (rst_i) begin
      dmem_req_o = w_req;
      if (w_mem_stall) begin
        // Freeze everything up to EX_MEM; bubble WB so nothing retires twice
        PCWrite_o       = 1'b0;
        IF_ID_Write_o   = 1'b0;
        ID_EX_Write_o   = 1'b0;
        EX_MEM_Write_o  = 1'b0;
        MEM_WB_Bubble_o = 1'b1;
      end else if (w_hazard) begin
        // Branch is suppressed; it re-resolves next cycle with forwarded data
        PCWrite_o      = 1'b0;
        IF_ID_Write_o  = 1'b0;
        ID_EX_Bubble_o = 1'b1;
      end else if (Branch_i) begin
        IF_ID_Flush_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_RUN;
      r_wcnt      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      if (!PCWrite_o && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  // ERR is only left through reset, so this is sticky by construction
  assign timeout_o   = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Purpose  : Self-checking bench for pipeline_ctrl (WAIT_MAX=4, CNT_W=4).
//            Directed scenarios followed by randomized traffic, all checked
//            against a behavioural model of the stall/flush rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  localparam int WMAX = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [4:0]    IF_ID_RS_i, IF_ID_RT_i, ID_EX_RT_i;
  logic          ID_EX_MemRead_i, Branch_i, EX_MEM_MemRead_i, EX_MEM_MemWrite_i, dmem_ack_i;
  logic          dmem_req_o, PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Write_o;
  logic          ID_EX_Bubble_o, EX_MEM_Write_o, MEM_WB_Bubble_o, timeout_o;
  logic [CW-1:0] stall_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;

  pipeline_ctrl #(.WAIT_MAX(WMAX), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .IF_ID_RS_i(IF_ID_RS_i), .IF_ID_RT_i(IF_ID_RT_i), .ID_EX_RT_i(ID_EX_RT_i),
    .ID_EX_MemRead_i(ID_EX_MemRead_i), .Branch_i(Branch_i),
    .EX_MEM_MemRead_i(EX_MEM_MemRead_i), .EX_MEM_MemWrite_i(EX_MEM_MemWrite_i),
    .dmem_ack_i(dmem_ack_i), .dmem_req_o(dmem_req_o), .PCWrite_o(PCWrite_o),
    .IF_ID_Write_o(IF_ID_Write_o), .IF_ID_Flush_o(IF_ID_Flush_o),
    .ID_EX_Write_o(ID_EX_Write_o), .ID_EX_Bubble_o(ID_EX_Bubble_o),
    .EX_MEM_Write_o(EX_MEM_Write_o), .MEM_WB_Bubble_o(MEM_WB_Bubble_o),
    .stall_cnt_o(stall_cnt_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural model: cycles spent waiting (0 = not waiting), dead flag,
  // and the number of stalled cycles seen since reset.
  int m_waited;
  bit m_dead;
  int m_stalls;
  bit e_req, e_pc, e_ifw, e_flush, e_idw, e_idb, e_exw, e_wbb;

  task automatic model_reset();
    m_waited = 0;
    m_dead   = 1'b0;
    m_stalls = 0;
  endtask

  task automatic model_outputs();
    bit memop, hz, stall;
    memop = EX_MEM_MemRead_i || EX_MEM_MemWrite_i;
    hz    = ID_EX_MemRead_i && (ID_EX_RT_i != 0) &&
            ((ID_EX_RT_i == IF_ID_RS_i) || (ID_EX_RT_i == IF_ID_RT_i));
    if (m_dead) begin
      e_req = 0; stall = 1;
    end else if (m_waited > 0) begin
      e_req = 1; stall = !dmem_ack_i;
    end else begin
      e_req = memop; stall = memop && !dmem_ack_i;
    end
    e_flush = 0; e_idb = 0;
    if (!rst_i) begin
      e_req = 0; e_pc = 1; e_ifw = 1; e_idw = 1; e_exw = 1; e_wbb = 0;
    end else if (stall) begin
      e_pc = 0; e_ifw = 0; e_idw = 0; e_exw = 0; e_wbb = 1;
    end else begin
      e_idw = 1; e_exw = 1; e_wbb = 0;
      e_pc  = !hz; e_ifw = !hz; e_idb = hz;
      e_flush = !hz && Branch_i;
    end
  endtask

  task automatic model_clock();
    bit memop;
    memop = EX_MEM_MemRead_i || EX_MEM_MemWrite_i;
    if (!e_pc && m_stalls < CMAX) m_stalls++;
    if (m_dead) begin
      // stays dead until reset
    end else if (m_waited > 0) begin
      if (dmem_ack_i)            m_waited = 0;
      else if (m_waited == WMAX) m_dead = 1'b1;
      else                       m_waited++;
    end else if (memop && !dmem_ack_i) begin
      m_waited = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    model_outputs();
    chk("dmem_req",   32'(dmem_req_o),      32'(e_req));
    chk("PCWrite",    32'(PCWrite_o),       32'(e_pc));
    chk("IF_ID_Wr",   32'(IF_ID_Write_o),   32'(e_ifw));
    chk("IF_ID_Fl",   32'(IF_ID_Flush_o),   32'(e_flush));
    chk("ID_EX_Wr",   32'(ID_EX_Write_o),   32'(e_idw));
    chk("ID_EX_Bub",  32'(ID_EX_Bubble_o),  32'(e_idb));
    chk("EX_MEM_Wr",  32'(EX_MEM_Write_o),  32'(e_exw));
    chk("MEM_WB_Bub", 32'(MEM_WB_Bubble_o), 32'(e_wbb));
    chk("stall_cnt",  32'(stall_cnt_o),     32'(m_stalls));
    chk("timeout",    32'(timeout_o),       32'(m_dead));
  endtask

  // Inputs are already set; check mid-cycle, then advance the model with the edge
  task automatic cycle();
    @(negedge clk_i);
    check_all();
    @(posedge clk_i);
    model_clock();
    #1;
  endtask

  task automatic set_in(input bit rd, input bit wr, input bit ack, input bit br,
                        input bit idrd, input int exrt, input int rs, input int rt);
    EX_MEM_MemRead_i = rd; EX_MEM_MemWrite_i = wr; dmem_ack_i = ack; Branch_i = br;
    ID_EX_MemRead_i = idrd; ID_EX_RT_i = 5'(exrt); IF_ID_RS_i = 5'(rs); IF_ID_RT_i = 5'(rt);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b1;
    set_in(1, 0, 0, 1, 1, 3, 3, 0);
    #2;
    // Reset with a would-be stall on the inputs: outputs must hold defaults
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Zero-wait access
    set_in(1, 0, 1, 0, 0, 0, 0, 0); cycle();
    chk("zw_cnt", 32'(stall_cnt_o), 32'd0);

    // 3-cycle miss on a store: ack on the third cycle
    set_in(0, 1, 0, 0, 0, 0, 0, 0); cycle(); cycle();
    set_in(0, 1, 1, 0, 0, 0, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle();
    chk("miss_cnt", 32'(stall_cnt_o), 32'd2);

    // Load-use on rs, then cleared; rt=0 is never a hazard
    set_in(0, 0, 0, 0, 1, 5, 5, 7); cycle();
    set_in(0, 0, 0, 0, 0, 5, 5, 7); cycle();
    set_in(0, 0, 0, 0, 1, 0, 0, 0); cycle();
    set_in(0, 0, 0, 0, 1, 9, 1, 9); cycle();

    // Branch with hazard (hazard wins), then branch alone (flush)
    set_in(0, 0, 0, 1, 1, 6, 6, 0); cycle();
    set_in(0, 0, 0, 1, 0, 6, 6, 0); cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle();

    // Timeout: request held without ack
    do_reset();
    set_in(1, 0, 0, 1, 1, 2, 2, 0);
    for (int i = 0; i < WMAX + 3; i++) cycle();
    chk("err_timeout", 32'(timeout_o), 32'd1);
    chk("err_req", 32'(dmem_req_o), 32'd0);
    // Asynchronous reset mid-ERR takes effect without a clock edge
    rst_i = 1'b0;
    model_reset();
    #1;
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_cnt", 32'(stall_cnt_o), 32'd0);
    chk("rst_pcw", 32'(PCWrite_o), 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle();

    // Counter saturation: 20 load-use cycles
    do_reset();
    set_in(0, 0, 0, 0, 1, 4, 0, 4);
    for (int i = 0; i < 20; i++) cycle();
    chk("sat_cnt", 32'(stall_cnt_o), 32'(CMAX));

    // Randomized traffic with periodic resets
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) do_reset();
      set_in($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It combines three inputs: load-use hazard detection (ID vs EX), branch/jump flush (ID), and a handshaked variable-latency data-memory access in MEM.
- Drives the write-enable/flush controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Inserts WB bubbles so no instruction retires twice during a memory stall.
- Counts stall cycles and flags a memory timeout.

Parameters:
WAIT_MAX, 64, max cycles in MEM_WAIT before declaring timeout
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
IF_ID_RS_i  in  5  rs field of instruction in ID
IF_ID_RT_i  in  5  rt field of instruction in ID
ID_EX_RT_i  in  5  rt (load destination) of instruction in EX
ID_EX_MemRead_i  in  1  instruction in EX is a load
Branch_i  in  1  branch taken / jump resolved in ID this cycle
EX_MEM_MemRead_i  in  1  instruction in MEM is a load
EX_MEM_MemWrite_i  in  1  instruction in MEM is a store
dmem_ack_i  in  1  data memory completes current access this cycle
dmem_req_o  out  1  data memory request
PCWrite_o  out  1  PC update enable
IF_ID_Write_o  out  1  IF_ID load enable
IF_ID_Flush_o  out  1  IF_ID cleared to nop
ID_EX_Write_o  out  1  ID_EX load enable
ID_EX_Bubble_o  out  1  ID_EX control fields zeroed
EX_MEM_Write_o  out  1  EX_MEM load enable
MEM_WB_Bubble_o  out  1  MEM_WB RegWrite/MemToReg forced 0
stall_cnt_o  out  CNT_W  saturating count of stalled cycles
timeout_o  out  1  sticky memory timeout flag

Behaviour:
- State machine has three states: RUN, MEM_WAIT, ERR. Reset (rst_i=0, async) → RUN, wait counter 0, stall_cnt_o 0, timeout_o 0.
- Outputs are combinational from state and inputs. Defaults are all write enables 1 and all flush/bubble/req 0. These are also the values held during reset.
- mem_op = EX_MEM_MemRead_i | EX_MEM_MemWrite_i.
- RUN:
  - dmem_req_o = mem_op.
  - mem_op & dmem_ack_i in the same cycle is a zero-wait access: no stall, stay in RUN.
  - mem_op & !dmem_ack_i is a mem stall in this cycle: PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write = 0; MEM_WB_Bubble_o = 1; next state MEM_WAIT; wait counter ← 1.
- MEM_WAIT:
  - dmem_req_o = 1 continuously; mem stall outputs as above.
  - On dmem_ack_i: stall released in that same cycle (all enables 1, bubble 0, MEM_WB captures the result); next state RUN; wait counter ← 0.
  - Without ack: wait counter +1.
  - When the counter = WAIT_MAX and there is no ack: next state ERR.
- ERR:
  - Full mem stall outputs are held and dmem_req_o = 0.
  - timeout_o = 1. Exit only via reset.
- Load-use hazard: ID_EX_MemRead_i & ID_EX_RT_i != 0 & (ID_EX_RT_i == IF_ID_RS_i | ID_EX_RT_i == IF_ID_RT_i).
  - Response: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1. EX_MEM and MEM_WB advance normally.
  - Exactly one cycle: after the bubble, the load leaves EX and the condition clears.
- Branch_i: IF_ID_Flush_o = 1 (the fetched wrong-path instruction is discarded). The PC loads the target normally.
- Priority, highest first: ERR, mem stall, load-use, branch.
  - During a mem stall, load-use and branch are suppressed and no bubble enters ID_EX; they are re-evaluated when the stall releases.
  - Load-use together with branch: load-use wins and IF_ID_Flush_o = 0; the branch is re-resolved next cycle with forwarded data.
- stall_cnt_o increments on every cycle where PCWrite_o = 0 (mem stall, load-use, or ERR). It saturates at all-ones and does not wrap.
- A reset asserted mid-access returns to RUN immediately. Any outstanding ack after reset release is handled as a fresh RUN-state event; the memory side must drop ack within one cycle of reset release.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding localparams (S_RUN=2'd0, S_WAIT=2'd1, S_ERR=2'd2);
  - the opcode/field width constants (REG_AW=5) shared with the hazard comparators.
- One natural sub-module, hazard_detect: pure combinational load-use comparator producing a single hazard flag. The FSM, counters and priority mux stay in pipeline_ctrl.

Test Plan:
- Zero-wait: EX_MEM_MemRead=1, dmem_ack=1 same cycle → dmem_req=1, all enables 1, state stays RUN, stall_cnt unchanged.
- 3-cycle miss: MemWrite=1, ack on 3rd cycle → enables 0 and MEM_WB_Bubble=1 for 2 cycles, released in the ack cycle, stall_cnt=2.
- Load-use: ID_EX_MemRead=1, ID_EX_RT=5, IF_ID_RS=5 → one cycle PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1. With ID_EX_RT=0 → no stall.
- Branch with load-use: Branch=1 plus hazard → IF_ID_Flush=0 and the stall is taken. Next cycle, Branch=1 with no hazard → IF_ID_Flush=1 for one cycle.
- Timeout with WAIT_MAX=4: mem_op held, no ack → ERR after the 4th wait cycle, timeout_o=1, dmem_req=0. Async rst_i low mid-ERR → RUN, timeout_o=0, stall_cnt=0 immediately.
- Saturation with CNT_W=4: 20 stalled cycles → stall_cnt_o=15.
